// File: rtl/aip_pkg.sv
// Shared AIP definitions for the share arbiter slice.
//   AIP_DATA_W / AIP_CONF_W : default AIP data and configuration bus widths
//   state_e                 : arbiter ownership state
//   M0 / M1                 : master index constants (M0 = picosoc, M1 = ipm bridge)
package aip_pkg;

    localparam int unsigned AIP_DATA_W = 32;
    localparam int unsigned AIP_CONF_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        RUN  = 2'd2
    } state_e;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

endpackage

// File: rtl/aip_rr_pick.sv
// Two-input round-robin pick.
//   req[1:0] : request vector, bit X set when master X wants the IP
//   last     : index of the master that owned the IP most recently
//   winner   : index of the picked master (valid only when valid=1)
//   valid    : at least one request present
module aip_rr_pick
    import aip_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner,
    output logic       valid
);

    always_comb begin
        valid  = |req;
        winner = M0;
        if (req == 2'b11) begin
            // Tie: the master that did not own last time goes first.
            winner = ~last;
        end else if (req[1]) begin
            winner = M1;
        end
    end

endmodule

// File: rtl/aip_share_arbiter.sv
// Shares one AIP slave core between two AIP masters (M0 = picosoc, M1 = ipm
// MCU bridge). The owner's commands are forwarded through one register stage,
// IP read data is broadcast, and the IP interrupt is routed to the master that
// issued start.
//   clk, rst_n                     : clock, synchronous active-low reset
//   mX_conf/read/write/start/data_in : master X command inputs
//   mX_data_out                    : IP read data, broadcast to both masters
//   mX_int_req                     : IP interrupt routed to the start issuer
//   mX_gnt                         : master X currently owns the IP (registered)
//   mX_denied                      : one-cycle pulse, a strobe of master X was dropped
//   ip_conf/read/write/start/data_in : registered commands to the IP core
//   ip_data_out, ip_int_req        : IP read data and level done interrupt
//   timeout_err                    : one-cycle pulse when RUN times out
module aip_share_arbiter
    import aip_pkg::*;
#(
    parameter int unsigned DATA_W      = AIP_DATA_W,
    parameter int unsigned CONF_W      = AIP_CONF_W,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned RUN_TIMEOUT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CONF_W-1:0] m0_conf,
    input  logic [CONF_W-1:0] m1_conf,
    input  logic              m0_read,
    input  logic              m1_read,
    input  logic              m0_write,
    input  logic              m1_write,
    input  logic              m0_start,
    input  logic              m1_start,
    input  logic [DATA_W-1:0] m0_data_in,
    input  logic [DATA_W-1:0] m1_data_in,
    output logic [DATA_W-1:0] m0_data_out,
    output logic [DATA_W-1:0] m1_data_out,
    output logic              m0_int_req,
    output logic              m1_int_req,
    output logic              m0_gnt,
    output logic              m1_gnt,
    output logic              m0_denied,
    output logic              m1_denied,
    output logic [CONF_W-1:0] ip_conf,
    output logic              ip_read,
    output logic              ip_write,
    output logic              ip_start,
    output logic [DATA_W-1:0] ip_data_in,
    input  logic [DATA_W-1:0] ip_data_out,
    input  logic              ip_int_req,
    output logic              timeout_err
);

    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned RUN_W  = (RUN_TIMEOUT > 1) ? $clog2(RUN_TIMEOUT) : 1;
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES - 1);
    // With the timeout disabled the run counter just saturates at all-ones.
    localparam logic [RUN_W-1:0]  RUN_MAX  = (RUN_TIMEOUT == 0) ? '1 : RUN_W'(RUN_TIMEOUT - 1);
    localparam bit                TO_EN    = (RUN_TIMEOUT != 0);

    state_e             state_q, state_d;
    logic               owner_q, owner_d;
    logic               last_owner_q, last_owner_d;
    logic               int_owner_q, int_owner_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [RUN_W-1:0]   run_cnt_q, run_cnt_d;
    logic [CONF_W-1:0]  ip_conf_q, ip_conf_d;
    logic [DATA_W-1:0]  ip_data_in_q, ip_data_in_d;
    logic               ip_read_q, ip_read_d;
    logic               ip_write_q, ip_write_d;
    logic               ip_start_q, ip_start_d;
    logic [1:0]         gnt_q, gnt_d;
    logic [1:0]         denied_q, denied_d;
    logic               timeout_err_q, timeout_err_d;

    logic [1:0] rd_v, wr_v, st_v, act_v;
    logic       pick_winner, pick_valid;
    logic       fwd, sel;

    assign rd_v  = {m1_read,  m0_read};
    assign wr_v  = {m1_write, m0_write};
    assign st_v  = {m1_start, m0_start};
    assign act_v = rd_v | wr_v | st_v;

    aip_rr_pick u_pick (
        .req    (act_v),
        .last   (last_owner_q),
        .winner (pick_winner),
        .valid  (pick_valid)
    );

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_owner_d  = last_owner_q;
        int_owner_d   = int_owner_q;
        hold_cnt_d    = hold_cnt_q;
        run_cnt_d     = run_cnt_q;
        ip_conf_d     = ip_conf_q;
        ip_data_in_d  = ip_data_in_q;
        ip_read_d     = 1'b0;
        ip_write_d    = 1'b0;
        ip_start_d    = 1'b0;
        denied_d      = '0;
        timeout_err_d = 1'b0;
        fwd           = 1'b0;
        sel           = owner_q;

        unique case (state_q)
            IDLE: begin
                // Grant on the same edge so the first strobe is captured, not lost.
                if (pick_valid) begin
                    fwd        = 1'b1;
                    sel        = pick_winner;
                    owner_d    = pick_winner;
                    hold_cnt_d = '0;
                    run_cnt_d  = '0;
                    if (st_v[pick_winner]) begin
                        state_d     = RUN;
                        int_owner_d = pick_winner;
                    end else begin
                        state_d = OWN;
                    end
                end
            end
            OWN: begin
                fwd = 1'b1;
                if (act_v[owner_q]) begin
                    hold_cnt_d = '0;
                    if (st_v[owner_q]) begin
                        state_d     = RUN;
                        int_owner_d = owner_q;
                        run_cnt_d   = '0;
                    end
                end else if (hold_cnt_q == HOLD_MAX) begin
                    state_d      = IDLE;
                    last_owner_d = owner_q;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            RUN: begin
                fwd = 1'b1;
                if (ip_int_req) begin
                    state_d    = OWN;
                    hold_cnt_d = '0;
                end else if (TO_EN && (run_cnt_q == RUN_MAX)) begin
                    state_d       = OWN;
                    hold_cnt_d    = '0;
                    timeout_err_d = 1'b1;
                end else if (run_cnt_q != RUN_MAX) begin
                    run_cnt_d = run_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // One shared forwarding path: the selected master drives the IP,
        // the other master's strobes are reported as denied.
        if (fwd) begin
            ip_read_d      = rd_v[sel];
            ip_write_d     = wr_v[sel];
            ip_start_d     = st_v[sel];
            ip_conf_d      = sel ? m1_conf    : m0_conf;
            ip_data_in_d   = sel ? m1_data_in : m0_data_in;
            denied_d[~sel] = act_v[~sel];
        end

        gnt_d = '0;
        if (state_d != IDLE) begin
            gnt_d[M1] = (owner_d == M1);
            gnt_d[M0] = (owner_d == M0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            owner_q       <= M0;
            last_owner_q  <= M1;
            int_owner_q   <= M0;
            hold_cnt_q    <= '0;
            run_cnt_q     <= '0;
            ip_conf_q     <= '0;
            ip_data_in_q  <= '0;
            ip_read_q     <= 1'b0;
            ip_write_q    <= 1'b0;
            ip_start_q    <= 1'b0;
            gnt_q         <= '0;
            denied_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_owner_q  <= last_owner_d;
            int_owner_q   <= int_owner_d;
            hold_cnt_q    <= hold_cnt_d;
            run_cnt_q     <= run_cnt_d;
            ip_conf_q     <= ip_conf_d;
            ip_data_in_q  <= ip_data_in_d;
            ip_read_q     <= ip_read_d;
            ip_write_q    <= ip_write_d;
            ip_start_q    <= ip_start_d;
            gnt_q         <= gnt_d;
            denied_q      <= denied_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign m0_data_out = ip_data_out;
    assign m1_data_out = ip_data_out;
    assign m0_int_req  = ip_int_req & (int_owner_q == M0);
    assign m1_int_req  = ip_int_req & (int_owner_q == M1);
    assign m0_gnt      = gnt_q[M0];
    assign m1_gnt      = gnt_q[M1];
    assign m0_denied   = denied_q[M0];
    assign m1_denied   = denied_q[M1];
    assign ip_conf     = ip_conf_q;
    assign ip_data_in  = ip_data_in_q;
    assign ip_read     = ip_read_q;
    assign ip_write    = ip_write_q;
    assign ip_start    = ip_start_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_aip_share_arbiter.sv
module tb_aip_share_arbiter;
    import aip_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  m0_conf, m1_conf;
    logic        m0_read, m1_read, m0_write, m1_write, m0_start, m1_start;
    logic [31:0] m0_data_in, m1_data_in;
    logic [31:0] ip_data_out;
    logic        ip_int_req;

    logic [31:0] m0_data_out, m1_data_out;
    logic        m0_int_req, m1_int_req, m0_gnt, m1_gnt, m0_denied, m1_denied;
    logic [4:0]  ip_conf;
    logic        ip_read, ip_write, ip_start;
    logic [31:0] ip_data_in;
    logic        timeout_err;

    logic [31:0] to_m0_data_out, to_m1_data_out;
    logic        to_m0_int_req, to_m1_int_req, to_m0_gnt, to_m1_gnt;
    logic        to_m0_denied, to_m1_denied;
    logic [4:0]  to_ip_conf;
    logic        to_ip_read, to_ip_write, to_ip_start;
    logic [31:0] to_ip_data_in;
    logic        to_timeout_err;

    always #5 clk = ~clk;

    aip_share_arbiter #(.DATA_W(32), .CONF_W(5), .HOLD_CYCLES(16), .RUN_TIMEOUT(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_conf(m0_conf), .m1_conf(m1_conf),
        .m0_read(m0_read), .m1_read(m1_read),
        .m0_write(m0_write), .m1_write(m1_write),
        .m0_start(m0_start), .m1_start(m1_start),
        .m0_data_in(m0_data_in), .m1_data_in(m1_data_in),
        .m0_data_out(m0_data_out), .m1_data_out(m1_data_out),
        .m0_int_req(m0_int_req), .m1_int_req(m1_int_req),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
        .m0_denied(m0_denied), .m1_denied(m1_denied),
        .ip_conf(ip_conf), .ip_read(ip_read), .ip_write(ip_write), .ip_start(ip_start),
        .ip_data_in(ip_data_in), .ip_data_out(ip_data_out), .ip_int_req(ip_int_req),
        .timeout_err(timeout_err)
    );

    aip_share_arbiter #(.DATA_W(32), .CONF_W(5), .HOLD_CYCLES(16), .RUN_TIMEOUT(8)) dut_to (
        .clk(clk), .rst_n(rst_n),
        .m0_conf(m0_conf), .m1_conf(m1_conf),
        .m0_read(m0_read), .m1_read(m1_read),
        .m0_write(m0_write), .m1_write(m1_write),
        .m0_start(m0_start), .m1_start(m1_start),
        .m0_data_in(m0_data_in), .m1_data_in(m1_data_in),
        .m0_data_out(to_m0_data_out), .m1_data_out(to_m1_data_out),
        .m0_int_req(to_m0_int_req), .m1_int_req(to_m1_int_req),
        .m0_gnt(to_m0_gnt), .m1_gnt(to_m1_gnt),
        .m0_denied(to_m0_denied), .m1_denied(to_m1_denied),
        .ip_conf(to_ip_conf), .ip_read(to_ip_read), .ip_write(to_ip_write), .ip_start(to_ip_start),
        .ip_data_in(to_ip_data_in), .ip_data_out(ip_data_out), .ip_int_req(ip_int_req),
        .timeout_err(to_timeout_err)
    );

    typedef struct packed {
        logic rd, wr, st, g0, g1, d0, d1;
        logic [4:0]  conf;
        logic [31:0] data;
    } obs_t;

    typedef struct {
        string tag;
        obs_t  v;
    } sb_t;

    sb_t        sb[$];
    logic [1:0] tq[$];   // {timeout_err, state is RUN} for the timeout instance
    int         n_tests = 0;
    int         n_fail  = 0;

    function automatic obs_t mk(input logic rd, input logic wr, input logic st,
                                input logic g0, input logic g1, input logic d0, input logic d1,
                                input logic [4:0] conf, input logic [31:0] data);
        mk = {rd, wr, st, g0, g1, d0, d1, conf, data};
    endfunction

    function automatic obs_t sample();
        return {ip_read, ip_write, ip_start, m0_gnt, m1_gnt, m0_denied, m1_denied,
                ip_conf, ip_data_in};
    endfunction

    task automatic push(input string tag, input obs_t v);
        sb_t e;
        e.tag = tag;
        e.v   = v;
        sb.push_back(e);
    endtask

    task automatic clear_strobes();
        m0_read = 0; m0_write = 0; m0_start = 0;
        m1_read = 0; m1_write = 0; m1_start = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        clear_strobes();
        m0_conf = '0; m1_conf = '0; m0_data_in = '0; m1_data_in = '0;
        ip_int_req = 0; ip_data_out = '0;
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_reset();
        sb_t e;
        obs_t o;
        do_reset();
        push("reset_outputs", mk(0,0,0,0,0,0,0,5'h00,32'h0));
        e = sb.pop_front(); o = sample(); n_tests++;
        if (o !== e.v) begin n_fail++; $display("FAIL %s: got %h want %h", e.tag, o, e.v); end
        n_tests++;
        if (dut.state_q !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", dut.state_q, IDLE); end
        n_tests++;
        if ({m0_int_req, m1_int_req, timeout_err, to_timeout_err} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_misc: got %b want 0000", {m0_int_req, m1_int_req, timeout_err, to_timeout_err});
        end
    endtask

    task automatic test_write_grant();
        sb_t e;
        obs_t o;
        do_reset();
        m0_write = 1; m0_conf = 5'h01; m0_data_in = 32'hDEADBEEF;
        push("write_fwd", mk(0,1,0,1,0,0,0,5'h01,32'hDEADBEEF));
        @(negedge clk);
        e = sb.pop_front(); o = sample(); n_tests++;
        if (o !== e.v) begin n_fail++; $display("FAIL %s: got %h want %h", e.tag, o, e.v); end
        n_tests++;
        if (dut.state_q !== OWN) begin n_fail++; $display("FAIL write_state: got %0d want %0d", dut.state_q, OWN); end
        // owner conf keeps flowing every cycle in OWN, strobes do not repeat
        m0_write = 0; m0_conf = 5'h07;
        push("own_conf_track", mk(0,0,0,1,0,0,0,5'h07,32'hDEADBEEF));
        @(negedge clk);
        e = sb.pop_front(); o = sample(); n_tests++;
        if (o !== e.v) begin n_fail++; $display("FAIL %s: got %h want %h", e.tag, o, e.v); end
    endtask

    task automatic test_deny_release();
        sb_t e;
        obs_t o;
        do_reset();
        m0_write = 1; m0_conf = 5'h01; m0_data_in = 32'hDEADBEEF;
        push("dr_grant", mk(0,1,0,1,0,0,0,5'h01,32'hDEADBEEF));
        @(negedge clk);
        e = sb.pop_front(); o = sample(); n_tests++;
        if (o !== e.v) begin n_fail++; $display("FAIL %s: got %h want %h", e.tag, o, e.v); end
        m0_write = 0;
        m1_read = 1; m1_conf = 5'h1F; m1_data_in = 32'hCAFEF00D;
        push("dr_m1_denied", mk(0,0,0,1,0,0,1,5'h01,32'hDEADBEEF));
        @(negedge clk);
        e = sb.pop_front(); o = sample(); n_tests++;
        if (o !== e.v) begin n_fail++; $display("FAIL %s: got %h want %h", e.tag, o, e.v); end
        m1_read = 0;
        // 16 owner-idle cycles (first one was the denied cycle): released after edge 17
        for (int k = 3; k <= 17; k++) begin
            push($sformatf("dr_hold_e%0d", k), mk(0,0,0,(k <= 16),0,0,0,5'h01,32'hDEADBEEF));
            @(negedge clk);
            e = sb.pop_front(); o = sample(); n_tests++;
            if (o !== e.v) begin n_fail++; $display("FAIL %s: got %h want %h", e.tag, o, e.v); end
        end
        m1_read = 1; m1_conf = 5'h0A; m1_data_in = 32'h11112222;
        push("dr_m1_after_release", mk(1,0,0,0,1,0,0,5'h0A,32'h11112222));
        @(negedge clk);
        e = sb.pop_front(); o = sample(); n_tests++;
        if (o !== e.v) begin n_fail++; $display("FAIL %s: got %h want %h", e.tag, o, e.v); end
        clear_strobes();
    endtask

    task automatic test_tie();
        sb_t e;
        obs_t o;
        do_reset();
        m0_write = 1; m0_conf = 5'h02; m0_data_in = 32'hA0A0A0A0;
        m1_write = 1; m1_conf = 5'h03; m1_data_in = 32'hB0B0B0B0;
        push("tie_first_m0", mk(0,1,0,1,0,0,1,5'h02,32'hA0A0A0A0));
        @(negedge clk);
        e = sb.pop_front(); o = sample(); n_tests++;
        if (o !== e.v) begin n_fail++; $display("FAIL %s: got %h want %h", e.tag, o, e.v); end
        clear_strobes();
        push("tie_released", mk(0,0,0,0,0,0,0,5'h02,32'hA0A0A0A0));
        repeat (16) @(negedge clk);
        e = sb.pop_front(); o = sample(); n_tests++;
        if (o !== e.v) begin n_fail++; $display("FAIL %s: got %h want %h", e.tag, o, e.v); end
        m0_write = 1; m0_conf = 5'h04; m0_data_in = 32'hA1A1A1A1;
        m1_write = 1; m1_conf = 5'h05; m1_data_in = 32'hB1B1B1B1;
        push("tie_second_m1", mk(0,1,0,0,1,1,0,5'h05,32'hB1B1B1B1));
        @(negedge clk);
        e = sb.pop_front(); o = sample(); n_tests++;
        if (o !== e.v) begin n_fail++; $display("FAIL %s: got %h want %h", e.tag, o, e.v); end
        clear_strobes();
    endtask

    task automatic test_run_int();
        sb_t e;
        obs_t o;
        do_reset();
        m1_start = 1; m1_conf = 5'h04; m1_data_in = 32'h00000055;
        push("run_start", mk(0,0,1,0,1,0,0,5'h04,32'h00000055));
        @(negedge clk);
        e = sb.pop_front(); o = sample(); n_tests++;
        if (o !== e.v) begin n_fail++; $display("FAIL %s: got %h want %h", e.tag, o, e.v); end
        n_tests++;
        if (dut.state_q !== RUN) begin n_fail++; $display("FAIL run_state: got %0d want %0d", dut.state_q, RUN); end
        // owner status read passes, non-owner write is denied while in RUN
        m1_start = 0; m1_read = 1;
        m0_write = 1; m0_conf = 5'h1F; m0_data_in = 32'hFFFFFFFF;
        push("run_status_read", mk(1,0,0,0,1,1,0,5'h04,32'h00000055));
        @(negedge clk);
        e = sb.pop_front(); o = sample(); n_tests++;
        if (o !== e.v) begin n_fail++; $display("FAIL %s: got %h want %h", e.tag, o, e.v); end
        clear_strobes();
        push("run_still_owned", mk(0,0,0,0,1,0,0,5'h04,32'h00000055));
        repeat (18) @(negedge clk);
        e = sb.pop_front(); o = sample(); n_tests++;
        if (o !== e.v) begin n_fail++; $display("FAIL %s: got %h want %h", e.tag, o, e.v); end
        n_tests++;
        if (dut.state_q !== RUN) begin n_fail++; $display("FAIL run_no_timeout: got %0d want %0d", dut.state_q, RUN); end
        ip_int_req = 1;
        #1;
        n_tests++;
        if ({m0_int_req, m1_int_req} !== 2'b01) begin
            n_fail++; $display("FAIL int_route_m1: got m0/m1 %b want 01", {m0_int_req, m1_int_req});
        end
        @(negedge clk);
        ip_int_req = 0;
        n_tests++;
        if (dut.state_q !== OWN || m1_gnt !== 1'b1 || timeout_err !== 1'b0) begin
            n_fail++; $display("FAIL int_to_own: got state %0d gnt %b to %b want %0d 1 0", dut.state_q, m1_gnt, timeout_err, OWN);
        end
    endtask

    task automatic test_timeout();
        logic [1:0] t;
        do_reset();
        m0_start = 1; m0_conf = 5'h06; m0_data_in = 32'h00000066;
        for (int k = 1; k <= 10; k++) begin
            tq.push_back({(k == 9), (k < 9)});
            @(negedge clk);
            clear_strobes();
            t = tq.pop_front();
            n_tests++;
            if ({to_timeout_err, (dut_to.state_q == RUN)} !== t) begin
                n_fail++; $display("FAIL timeout_e%0d: got to/run %b%b want %b", k, to_timeout_err, (dut_to.state_q == RUN), t);
            end
        end
        n_tests++;
        if (dut_to.state_q !== OWN || to_m0_gnt !== 1'b1) begin
            n_fail++; $display("FAIL timeout_own: got state %0d gnt %b want %0d 1", dut_to.state_q, to_m0_gnt, OWN);
        end
        n_tests++;
        if (dut.state_q !== RUN || timeout_err !== 1'b0) begin
            n_fail++; $display("FAIL no_timeout_default: got state %0d to %b want %0d 0", dut.state_q, timeout_err, RUN);
        end
    endtask

    task automatic test_back_to_back();
        sb_t e;
        obs_t o;
        do_reset();
        for (int i = 0; i <= 4; i++) begin
            if (i > 0) begin
                e = sb.pop_front(); o = sample(); n_tests++;
                if (o !== e.v) begin n_fail++; $display("FAIL %s: got %h want %h", e.tag, o, e.v); end
            end
            clear_strobes();
            case (i)
                0: begin
                    m0_write = 1; m0_conf = 5'h01; m0_data_in = 32'h11;
                    push("b2b_write", mk(0,1,0,1,0,0,0,5'h01,32'h11));
                end
                1: begin
                    m0_read = 1; m0_conf = 5'h02; m0_data_in = 32'h22;
                    m1_read = 1;
                    push("b2b_read", mk(1,0,0,1,0,0,1,5'h02,32'h22));
                end
                2: begin
                    m0_start = 1; m0_conf = 5'h03; m0_data_in = 32'h33;
                    push("b2b_start", mk(0,0,1,1,0,0,0,5'h03,32'h33));
                end
                3: push("b2b_quiet", mk(0,0,0,1,0,0,0,5'h03,32'h33));
                default: ;
            endcase
            if (i < 4) @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_run();
        sb_t e;
        obs_t o;
        do_reset();
        m1_start = 1; m1_conf = 5'h04; m1_data_in = 32'h44;
        @(negedge clk);
        clear_strobes();
        repeat (3) @(negedge clk);
        rst_n = 0; ip_int_req = 1; ip_data_out = 32'h600DF00D;
        push("midrun_reset", mk(0,0,0,0,0,0,0,5'h00,32'h0));
        @(negedge clk);
        e = sb.pop_front(); o = sample(); n_tests++;
        if (o !== e.v) begin n_fail++; $display("FAIL %s: got %h want %h", e.tag, o, e.v); end
        n_tests++;
        if (dut.state_q !== IDLE) begin n_fail++; $display("FAIL midrun_state: got %0d want %0d", dut.state_q, IDLE); end
        n_tests++;
        if ({m0_int_req, m1_int_req} !== 2'b10) begin
            n_fail++; $display("FAIL midrun_int_m0: got m0/m1 %b want 10", {m0_int_req, m1_int_req});
        end
        n_tests++;
        if (m0_data_out !== 32'h600DF00D || m1_data_out !== 32'h600DF00D) begin
            n_fail++; $display("FAIL data_broadcast: got %h/%h want 600df00d", m0_data_out, m1_data_out);
        end
        rst_n = 1; ip_int_req = 0;
    endtask

    initial begin
        clear_strobes();
        m0_conf = '0; m1_conf = '0; m0_data_in = '0; m1_data_in = '0;
        ip_int_req = 0; ip_data_out = '0;
        test_reset();
        test_write_grant();
        test_deny_release();
        test_tie();
        test_run_int();
        test_timeout();
        test_back_to_back();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
